// File: rtl/xor_parity_stream_pkg.sv
// Shared constants for the xor_parity_stream block: FSM state encoding and frame modes.
package xor_parity_stream_pkg;

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/xor_parity_stream_if.sv
// Word-stream input and integrity-result output of xor_parity_stream, both valid/ready.
interface xor_parity_stream_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_lpar;
  logic              out_vpar;
  logic              out_err;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  // The block itself: consumes beats, produces results.
  modport slave (
    input  in_valid, in_data, in_last, in_mode, out_ready,
    output in_ready, out_valid, out_lpar, out_vpar, out_err, out_count, out_ovf
  );

  modport master (
    output in_valid, in_data, in_last, in_mode, out_ready,
    input  in_ready, out_valid, out_lpar, out_vpar, out_err, out_count, out_ovf
  );

endinterface

// File: rtl/xor_parity_stream_xor_reduce.sv
// Combinational WIDTH-bit reduction XOR; the parent registers the result.
module xor_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_parity
);

  assign o_parity = ^i_data;

endmodule

// File: rtl/xor_parity_stream.sv
// Streaming longitudinal/bit parity generator and checker over frames of DATA_W-bit words.
module xor_parity_stream
  import xor_parity_stream_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 16,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  xor_parity_stream_if.slave bus
);

  localparam logic              OddBit  = (ODD_PARITY != 0);
  localparam logic [DATA_W-1:0] ParMask = {DATA_W{OddBit}};
  localparam logic [CNT_W-1:0]  CntMax  = '1;

  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_mode;
  logic              r_midFrame;

  logic [DATA_W-1:0] r_lpar;
  logic              r_vpar;
  logic              r_err;
  logic [CNT_W-1:0]  r_outCount;
  logic              r_outOvf;

  logic              w_inFire;
  logic              w_outFire;
  logic              w_mode;
  logic              w_isData;
  logic              w_sat;
  logic [DATA_W-1:0] w_accNext;
  logic [CNT_W-1:0]  w_countNext;
  logic              w_ovfNext;
  logic              w_vparRaw;
  logic              w_errNext;

  assign w_inFire  = bus.in_valid && (r_state == ST_ACC);
  assign w_outFire = bus.out_ready && (r_state == ST_OUT);

  // Mode is taken live on the first beat, then from the latch for the rest of the frame.
  assign w_mode      = r_midFrame ? r_mode : bus.in_mode;
  assign w_isData    = !(bus.in_last && (w_mode == MODE_CHK));
  assign w_sat       = (r_count == CntMax);
  assign w_accNext   = w_isData ? (r_acc ^ bus.in_data) : r_acc;
  assign w_countNext = (w_isData && !w_sat) ? (r_count + CNT_W'(1)) : r_count;
  assign w_ovfNext   = r_ovf || (w_isData && w_sat);
  assign w_errNext   = (w_mode == MODE_CHK) && ((r_acc ^ ParMask) != bus.in_data);

  xor_reduce #(
    .WIDTH (DATA_W)
  ) u_xor_reduce (
    .i_data   (w_accNext),
    .o_parity (w_vparRaw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ACC;
      r_acc      <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_mode     <= MODE_GEN;
      r_midFrame <= 1'b0;
    end else if (r_state == ST_ACC) begin
      if (w_inFire) begin
        r_acc   <= w_accNext;
        r_count <= w_countNext;
        r_ovf   <= w_ovfNext;
        if (!r_midFrame) begin
          r_mode <= bus.in_mode;
        end
        if (bus.in_last) begin
          r_midFrame <= 1'b0;
          r_state    <= ST_OUT;
        end else begin
          r_midFrame <= 1'b1;
        end
      end
    end else begin
      if (w_outFire) begin
        r_state <= ST_ACC;
        r_acc   <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end
    end
  end

  // Result registers load only on the last beat and hold after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lpar     <= '0;
      r_vpar     <= 1'b0;
      r_err      <= 1'b0;
      r_outCount <= '0;
      r_outOvf   <= 1'b0;
    end else if (w_inFire && bus.in_last) begin
      r_lpar     <= w_accNext ^ ParMask;
      r_vpar     <= w_vparRaw ^ OddBit;
      r_err      <= w_errNext;
      r_outCount <= w_countNext;
      r_outOvf   <= w_ovfNext;
    end
  end

  assign bus.in_ready  = (r_state == ST_ACC);
  assign bus.out_valid = (r_state == ST_OUT);
  assign bus.out_lpar  = r_lpar;
  assign bus.out_vpar  = r_vpar;
  assign bus.out_err   = r_err;
  assign bus.out_count = r_outCount;
  assign bus.out_ovf   = r_outOvf;

endmodule

// File: tb/tb_xor_parity_stream.sv
// Directed self-checking bench: even/odd parity and narrow-counter instances of xor_parity_stream.
module tb_xor_parity_stream;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  xor_parity_stream_if #(.DATA_W(8), .CNT_W(16)) bus0 ();
  xor_parity_stream_if #(.DATA_W(8), .CNT_W(16)) bus1 ();
  xor_parity_stream_if #(.DATA_W(8), .CNT_W(2))  bus2 ();

  xor_parity_stream #(.DATA_W(8), .CNT_W(16), .ODD_PARITY(0)) dutEven (
    .clk (clk), .rst_n (rst_n), .bus (bus0.slave)
  );
  xor_parity_stream #(.DATA_W(8), .CNT_W(16), .ODD_PARITY(1)) dutOdd (
    .clk (clk), .rst_n (rst_n), .bus (bus1.slave)
  );
  xor_parity_stream #(.DATA_W(8), .CNT_W(2), .ODD_PARITY(0)) dutNarrow (
    .clk (clk), .rst_n (rst_n), .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic getInReady(int sel);
    case (sel)
      0:       return bus0.in_ready;
      1:       return bus1.in_ready;
      default: return bus2.in_ready;
    endcase
  endfunction

  function automatic logic getOutValid(int sel);
    case (sel)
      0:       return bus0.out_valid;
      1:       return bus1.out_valid;
      default: return bus2.out_valid;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checks++;
    errors++;
    $display("[TB] FAIL %s: observed timeout expected handshake", tag);
  endtask

  task automatic driveIn(input int sel, input logic v, input logic [7:0] d, input logic last, input logic mode);
    case (sel)
      0: begin bus0.in_valid = v; bus0.in_data = d; bus0.in_last = last; bus0.in_mode = mode; end
      1: begin bus1.in_valid = v; bus1.in_data = d; bus1.in_last = last; bus1.in_mode = mode; end
      default: begin bus2.in_valid = v; bus2.in_data = d; bus2.in_last = last; bus2.in_mode = mode; end
    endcase
  endtask

  task automatic driveOutReady(input int sel, input logic r);
    case (sel)
      0:       bus0.out_ready = r;
      1:       bus1.out_ready = r;
      default: bus2.out_ready = r;
    endcase
  endtask

  // One beat, held until the block is ready, then released just after the accepting edge.
  task automatic applyStimulus(input int sel, input logic [7:0] d, input logic last, input logic mode);
    int n;
    n = 0;
    driveIn(sel, 1'b1, d, last, mode);
    #1;
    while (!getInReady(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) timeoutFail("in_ready wait");
    @(posedge clk);
    #1;
    driveIn(sel, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic waitResult(input int sel);
    int n;
    n = 0;
    @(negedge clk);
    while (!getOutValid(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) timeoutFail("out_valid wait");
  endtask

  task automatic acceptResult(input int sel);
    @(negedge clk);
    driveOutReady(sel, 1'b1);
    @(posedge clk);
    #1;
    driveOutReady(sel, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int s = 0; s < 3; s++) begin
      driveIn(s, 1'b0, 8'h00, 1'b0, 1'b0);
      driveOutReady(s, 1'b0);
    end
    repeat (3) @(negedge clk);

    checkOutput("reset out_valid", 32'(bus0.out_valid), 32'd0);
    checkOutput("reset out_lpar", 32'(bus0.out_lpar), 32'h00);
    checkOutput("reset out_count", 32'(bus0.out_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release in_ready", 32'(bus0.in_ready), 32'd1);

    $display("[TB] generate frame 0F F0 3C");
    applyStimulus(0, 8'h0F, 1'b0, 1'b0);
    applyStimulus(0, 8'hF0, 1'b0, 1'b0);
    applyStimulus(0, 8'h3C, 1'b1, 1'b0);
    waitResult(0);
    checkOutput("gen lpar", 32'(bus0.out_lpar), 32'hC3);
    checkOutput("gen vpar", 32'(bus0.out_vpar), 32'd0);
    checkOutput("gen count", 32'(bus0.out_count), 32'd3);
    checkOutput("gen err", 32'(bus0.out_err), 32'd0);
    checkOutput("gen ovf", 32'(bus0.out_ovf), 32'd0);
    acceptResult(0);
    checkOutput("gen accepted out_valid", 32'(bus0.out_valid), 32'd0);

    $display("[TB] check frame 12 34 26, mode low after first beat");
    applyStimulus(0, 8'h12, 1'b0, 1'b1);
    applyStimulus(0, 8'h34, 1'b0, 1'b0);
    applyStimulus(0, 8'h26, 1'b1, 1'b0);
    waitResult(0);
    checkOutput("chk ok err", 32'(bus0.out_err), 32'd0);
    checkOutput("chk ok lpar", 32'(bus0.out_lpar), 32'h26);
    checkOutput("chk ok count", 32'(bus0.out_count), 32'd2);
    checkOutput("chk ok vpar", 32'(bus0.out_vpar), 32'd1);
    acceptResult(0);

    applyStimulus(0, 8'h12, 1'b0, 1'b1);
    applyStimulus(0, 8'h34, 1'b0, 1'b1);
    applyStimulus(0, 8'h27, 1'b1, 1'b1);
    waitResult(0);
    checkOutput("chk bad err", 32'(bus0.out_err), 32'd1);
    checkOutput("chk bad lpar", 32'(bus0.out_lpar), 32'h26);
    acceptResult(0);

    $display("[TB] odd parity single beat A5");
    applyStimulus(1, 8'hA5, 1'b1, 1'b0);
    waitResult(1);
    checkOutput("odd lpar", 32'(bus1.out_lpar), 32'h5A);
    checkOutput("odd vpar", 32'(bus1.out_vpar), 32'd1);
    checkOutput("odd count", 32'(bus1.out_count), 32'd1);
    checkOutput("odd err", 32'(bus1.out_err), 32'd0);
    acceptResult(1);

    $display("[TB] backpressure");
    applyStimulus(0, 8'h81, 1'b1, 1'b0);
    waitResult(0);
    driveIn(0, 1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp out_valid", 32'(bus0.out_valid), 32'd1);
      checkOutput("bp in_ready", 32'(bus0.in_ready), 32'd0);
      checkOutput("bp lpar held", 32'(bus0.out_lpar), 32'h81);
    end
    driveOutReady(0, 1'b1);
    @(posedge clk);
    #1;
    driveOutReady(0, 1'b0);
    @(posedge clk);
    #1;
    driveIn(0, 1'b0, 8'h00, 1'b0, 1'b0);
    waitResult(0);
    checkOutput("bp next lpar", 32'(bus0.out_lpar), 32'h55);
    checkOutput("bp next count", 32'(bus0.out_count), 32'd1);
    checkOutput("bp next vpar", 32'(bus0.out_vpar), 32'd0);
    acceptResult(0);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 8'h11, 1'b0, 1'b0);
    applyStimulus(0, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst out_valid", 32'(bus0.out_valid), 32'd0);
    checkOutput("rst out_lpar", 32'(bus0.out_lpar), 32'h00);
    checkOutput("rst out_count", 32'(bus0.out_count), 32'd0);
    checkOutput("rst out_vpar", 32'(bus0.out_vpar), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 8'h01, 1'b1, 1'b0);
    waitResult(0);
    checkOutput("post rst lpar", 32'(bus0.out_lpar), 32'h01);
    checkOutput("post rst count", 32'(bus0.out_count), 32'd1);
    checkOutput("post rst vpar", 32'(bus0.out_vpar), 32'd1);
    acceptResult(0);

    $display("[TB] narrow counter saturation");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2, 8'h00, (i == 4), 1'b0);
    end
    waitResult(2);
    checkOutput("sat count", 32'(bus2.out_count), 32'd3);
    checkOutput("sat ovf", 32'(bus2.out_ovf), 32'd1);
    acceptResult(2);
    applyStimulus(2, 8'h00, 1'b1, 1'b0);
    waitResult(2);
    checkOutput("after sat ovf", 32'(bus2.out_ovf), 32'd0);
    checkOutput("after sat count", 32'(bus2.out_count), 32'd1);
    acceptResult(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_parity_stream.md
Name: xor_parity_stream

Overview:
- Parametrised streaming successor of the single-bit XOR gate. Folds a frame of DATA_W-bit words into a running column XOR (longitudinal parity) and a whole-frame bit parity.
- Generate mode: reports the parity word at end of frame. Check mode: compares the frame against an expected parity word carried on the last beat.
- Sits between a word-stream producer and a consumer of integrity results. Uses valid/ready handshakes on both sides.

Parameters:
DATA_W, 8, width of each data word and of the parity word
CNT_W, 16, width of the beat counter
ODD_PARITY, 0, 0 = even parity, 1 = odd parity (inverts every reported parity bit)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_data  input  DATA_W  data word, or expected parity on the last beat in check mode
in_last  input  1  beat is the last of the frame
in_mode  input  1  0 = generate, 1 = check; sampled on the first beat of a frame
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_lpar  output  DATA_W  column parity of the frame's data beats
out_vpar  output  1  parity of all data bits in the frame
out_err  output  1  check mode: mismatch; always 0 in generate mode
out_count  output  CNT_W  number of data beats in the frame (saturating)
out_ovf  output  1  the beat count saturated during the frame

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=ACC; accumulator, count, ovf, mode and first-flag cleared.
  - out_valid=0, out_lpar=0, out_vpar=0, out_err=0, out_count=0, out_ovf=0.
  - in_ready=1 once reset is released.
- A beat transfers when in_valid&&in_ready. A result transfers when out_valid&&out_ready.
- State ACC: in_ready=1, out_valid=0.
  - First beat of a frame: latches in_mode into mode_q, and the latched value governs the whole frame.
  - Data beat (generate mode, any beat; check mode, non-last beats): acc<=acc^in_data; count<=count+1, saturating at 2^CNT_W-1. Saturation sets ovf, which is sticky for the frame.
  - Last beat:
    - Generate mode: included in the accumulation.
    - Check mode: not accumulated and not counted. err = ((acc^{DATA_W{ODD_PARITY}}) != in_data).
    - Result registers are loaded and the state moves to OUT.
- State OUT: in_ready=0, out_valid=1.
  - Outputs are registered and held stable until accepted.
  - out_lpar = acc ^ {DATA_W{ODD_PARITY}}.
  - out_vpar = (^acc) ^ ODD_PARITY.
  - On out_ready: state moves to ACC; acc, count and ovf are cleared. The output registers keep their values but are no longer valid.
- Latency: out_valid rises on the clock edge that accepts the last beat, visible the next cycle. There is no bypass, so one bubble cycle occurs between frames minimum.
- Single-beat frames:
  - Generate mode: lpar = that word, count = 1.
  - Check mode: acc=0, count=0, err = (in_data != {DATA_W{ODD_PARITY}}).
- in_data is ignored when in_valid=0. in_last without in_valid has no effect.
- Reset mid-frame or while in OUT: partial frame and pending result are discarded. No output is produced for that frame.
- All state is held in registers; no combinational path from in_* to out_*.

Decomposition:
- Shared include/package holds: the state encoding localparams (ST_ACC, ST_OUT) and the mode constants (MODE_GEN=0, MODE_CHK=1).
- One sub-module: xor_reduce, a parametrised WIDTH-bit reduction XOR used for out_vpar. Purely combinational; its output is registered by the parent.

Test Plan:
- DATA_W=8, generate mode: 0x0F, 0xF0, 0x3C(last) -> out_lpar=0xC3, out_vpar=0, out_count=3, out_err=0, out_ovf=0.
- Check mode: 0x12, 0x34, 0x26(last) -> out_err=0, out_lpar=0x26, out_count=2. Repeat with last beat 0x27 -> out_err=1, out_lpar=0x26.
- ODD_PARITY=1, generate mode, single beat 0xA5(last) -> out_lpar=0x5A, out_vpar=1, out_count=1.
- Backpressure: hold out_ready=0 for 5 cycles after a result, with in_valid=1 presenting 0x55 -> outputs stable, in_ready=0, 0x55 not consumed. Then out_ready=1 -> next frame starts clean; 0x55(last) gives out_lpar=0x55.
- Assert rst_n=0 after 2 beats of a frame -> all outputs 0 immediately. After release, frame 0x01(last) -> out_lpar=0x01, out_count=1, out_vpar=1.
- CNT_W=2, generate mode, 5 beats of 0x00 -> out_count=3, out_ovf=1. Next frame of 1 beat -> out_ovf=0, out_count=1.
